// File: rtl/wb_data_mem_slave_if.sv
// wb_data_mem_slave_if: pipelined Wishbone B4 data-port bundle between core (master) and memory (slave).
interface wb_data_mem_slave_if;
  logic        i_wb_cyc;
  logic        i_wb_stb;
  logic        i_wb_we;
  logic [31:0] i_wb_addr;
  logic [31:0] i_wb_data;
  logic [3:0]  i_wb_sel;
  logic        o_wb_stall;
  logic        o_wb_ack;
  logic        o_wb_err;
  logic [31:0] o_wb_data;
  modport master (
    output i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data, i_wb_sel,
    input  o_wb_stall, o_wb_ack, o_wb_err, o_wb_data
  );
  modport slave (
    input  i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data, i_wb_sel,
    output o_wb_stall, o_wb_ack, o_wb_err, o_wb_data
  );
endinterface

// File: rtl/wb_data_mem_slave.sv
// wb_data_mem_slave: pipelined Wishbone slave RAM with byte-lane writes, fixed response latency
// and an outstanding-request limit enforced through stall.
module wb_data_mem_slave #(
  parameter int ADDR_WIDTH      = 10,
  parameter int LATENCY         = 2,
  parameter int MAX_OUTSTANDING = 2
) (
  input logic              i_clk,
  input logic              i_rst,
  wb_data_mem_slave_if.slave wb
);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  logic [31:0]           r_mem [2**ADDR_WIDTH];
  logic [LATENCY-1:0]    r_vld;
  logic [LATENCY-1:0]    r_err;
  logic [31:0]           r_dat [LATENCY];
  logic [CW-1:0]         r_cnt;
  logic                  w_acc;
  logic                  w_ok;
  logic                  w_resp;
  logic [ADDR_WIDTH-1:0] w_idx;
  assign wb.o_wb_stall = r_cnt == CW'(MAX_OUTSTANDING);
  assign w_acc         = wb.i_wb_cyc & wb.i_wb_stb & ~wb.o_wb_stall;
  assign w_ok          = wb.i_wb_addr[31:ADDR_WIDTH+2] == '0;
  assign w_idx         = wb.i_wb_addr[ADDR_WIDTH+1:2];
  assign w_resp        = r_vld[LATENCY-1];
  assign wb.o_wb_ack   = wb.i_wb_cyc & w_resp & ~r_err[LATENCY-1];
  assign wb.o_wb_err   = wb.i_wb_cyc & w_resp & r_err[LATENCY-1];
  // Pipe data is already zero for writes and errors, so only ack gating is needed here
  assign wb.o_wb_data  = wb.o_wb_ack ? r_dat[LATENCY-1] : '0;
  always_ff @(posedge i_clk)
    if (i_rst & w_acc & w_ok & wb.i_wb_we)
      for (int b = 0; b < 4; b++)
        if (wb.i_wb_sel[b]) r_mem[w_idx][8*b +: 8] <= wb.i_wb_data[8*b +: 8];
  always_ff @(posedge i_clk or negedge i_rst)
    if (!i_rst) begin
      r_vld <= '0;
      r_err <= '0;
      r_cnt <= '0;
      for (int i = 0; i < LATENCY; i++) r_dat[i] <= '0;
    end else begin
      r_vld[0] <= w_acc;
      r_err[0] <= ~w_ok;
      r_dat[0] <= (w_acc & w_ok & ~wb.i_wb_we) ? r_mem[w_idx] : '0;
      for (int i = 1; i < LATENCY; i++) begin
        r_vld[i] <= wb.i_wb_cyc & r_vld[i-1];
        r_err[i] <= r_err[i-1];
        r_dat[i] <= r_dat[i-1];
      end
      r_cnt <= !wb.i_wb_cyc ? '0 : r_cnt + CW'(w_acc) - CW'(w_resp);
    end
endmodule

// File: tb/tb_wb_data_mem_slave.sv
// tb_wb_data_mem_slave: directed vectors on a LAT=2/MAX=2 instance plus stall, abort and
// reset sequences, with a LAT=3/MAX=2 instance for the throughput-limited cases.
module tb_wb_data_mem_slave;
  logic clk = 0;
  logic rst_n = 0;
  int   tests = 0;
  int   fails = 0;
  always #5 clk = ~clk;
  wb_data_mem_slave_if if0 ();
  wb_data_mem_slave_if if1 ();
  wb_data_mem_slave #(.ADDR_WIDTH(10), .LATENCY(2), .MAX_OUTSTANDING(2))
    u0 (.i_clk(clk), .i_rst(rst_n), .wb(if0.slave));
  wb_data_mem_slave #(.ADDR_WIDTH(10), .LATENCY(3), .MAX_OUTSTANDING(2))
    u1 (.i_clk(clk), .i_rst(rst_n), .wb(if1.slave));
  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  sel;
    logic        err;
    logic [31:0] rdata;
  } vec_t;
  vec_t vecs [19];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask
  // Single isolated request on the LAT=2 instance: response exactly in the cycle after edge k+1
  task automatic run_vec(input vec_t v);
    @(negedge clk);
    if0.i_wb_cyc = 1; if0.i_wb_stb = 1; if0.i_wb_we = v.we;
    if0.i_wb_addr = v.addr; if0.i_wb_data = v.wdata; if0.i_wb_sel = v.sel;
    @(negedge clk);
    if0.i_wb_stb = 0; if0.i_wb_we = 0;
    chk("early_resp", {31'b0, if0.o_wb_ack | if0.o_wb_err}, 0);
    @(negedge clk);
    chk("resp_ack", {31'b0, if0.o_wb_ack}, {31'b0, ~v.err});
    chk("resp_err", {31'b0, if0.o_wb_err}, {31'b0, v.err});
    chk("resp_data", if0.o_wb_data, v.rdata);
    @(negedge clk);
    chk("post_resp", {31'b0, if0.o_wb_ack | if0.o_wb_err}, 0);
  endtask
  // Six requests to words 0..5 of the LAT=3/MAX=2 instance with stb held high
  task automatic stream1(input logic we);
    int   sent = 0;
    int   got = 0;
    logic acc;
    @(negedge clk);
    if1.i_wb_cyc = 1; if1.i_wb_stb = 1; if1.i_wb_we = we;
    if1.i_wb_addr = 0; if1.i_wb_data = 32'hA500_0000; if1.i_wb_sel = 4'hF;
    for (int c = 0; c < 60 && got < 6; c++) begin
      acc = if1.i_wb_stb & ~if1.o_wb_stall;
      @(negedge clk);
      if (acc) sent++;
      chk("stream_stall", {31'b0, if1.o_wb_stall}, {31'b0, (sent - got) == 2});
      chk("stream_err", {31'b0, if1.o_wb_err}, 0);
      if (if1.o_wb_ack) begin
        chk("stream_data", if1.o_wb_data, we ? 32'h0 : (32'hA500_0000 | 32'(got)));
        got++;
      end
      if (sent < 6) begin
        if1.i_wb_addr = 32'(sent * 4);
        if1.i_wb_data = 32'hA500_0000 | 32'(sent);
      end else if1.i_wb_stb = 0;
    end
    chk("stream_acks", 32'(got), 6);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
  initial begin
    vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 1'b0, 32'hDEAD_BEEF};
    vecs[2]  = '{1'b1, 32'h0000_0020, 32'hFFFF_FFFF, 4'hF, 1'b0, 32'h0};
    vecs[3]  = '{1'b1, 32'h0000_0020, 32'h1122_3344, 4'h5, 1'b0, 32'h0};
    vecs[4]  = '{1'b0, 32'h0000_0020, 32'h0,         4'hF, 1'b0, 32'hFF22_FF44};
    vecs[5]  = '{1'b1, 32'h0000_0000, 32'hCAFE_F00D, 4'hF, 1'b0, 32'h0};
    vecs[6]  = '{1'b0, 32'h0000_1000, 32'h0,         4'hF, 1'b1, 32'h0};
    vecs[7]  = '{1'b1, 32'h0000_1000, 32'h1234_5678, 4'hF, 1'b1, 32'h0};
    vecs[8]  = '{1'b0, 32'h0000_0000, 32'h0,         4'hF, 1'b0, 32'hCAFE_F00D};
    vecs[9]  = '{1'b1, 32'h0000_0024, 32'h5555_5555, 4'hF, 1'b0, 32'h0};
    vecs[10] = '{1'b1, 32'h0000_0024, 32'hAAAA_AAAA, 4'h0, 1'b0, 32'h0};
    vecs[11] = '{1'b0, 32'h0000_0024, 32'h0,         4'hF, 1'b0, 32'h5555_5555};
    vecs[12] = '{1'b1, 32'h0000_0013, 32'h7700_0000, 4'h8, 1'b0, 32'h0};
    vecs[13] = '{1'b0, 32'h0000_0012, 32'h0,         4'h1, 1'b0, 32'h77AD_BEEF};
    vecs[14] = '{1'b1, 32'h0000_0FFC, 32'h0BAD_CAFE, 4'hF, 1'b0, 32'h0};
    vecs[15] = '{1'b0, 32'h0000_0FFC, 32'h0,         4'hF, 1'b0, 32'h0BAD_CAFE};
    vecs[16] = '{1'b0, 32'h8000_0000, 32'h0,         4'hF, 1'b1, 32'h0};
    vecs[17] = '{1'b1, 32'h8000_0000, 32'h9999_9999, 4'hF, 1'b1, 32'h0};
    vecs[18] = '{1'b0, 32'h0000_0000, 32'h0,         4'hF, 1'b0, 32'hCAFE_F00D};
    {if0.i_wb_cyc, if0.i_wb_stb, if0.i_wb_we, if0.i_wb_addr, if0.i_wb_data, if0.i_wb_sel} = '0;
    {if1.i_wb_cyc, if1.i_wb_stb, if1.i_wb_we, if1.i_wb_addr, if1.i_wb_data, if1.i_wb_sel} = '0;
    repeat (3) @(negedge clk);
    chk("rst_ack", {31'b0, if0.o_wb_ack | if1.o_wb_ack}, 0);
    chk("rst_err", {31'b0, if0.o_wb_err | if1.o_wb_err}, 0);
    chk("rst_stall", {31'b0, if0.o_wb_stall | if1.o_wb_stall}, 0);
    chk("rst_data", if0.o_wb_data | if1.o_wb_data, 0);
    rst_n = 1;
    if0.i_wb_cyc = 1; if1.i_wb_cyc = 1;
    repeat (10) begin
      @(negedge clk);
      chk("idle_resp", {31'b0, if0.o_wb_ack | if0.o_wb_err | if1.o_wb_ack | if1.o_wb_err}, 0);
    end
    for (int i = 0; i < 19; i++) run_vec(vecs[i]);
    // Write then read the same word on consecutive edges
    @(negedge clk);
    if0.i_wb_stb = 1; if0.i_wb_we = 1; if0.i_wb_addr = 32'h30;
    if0.i_wb_data = 32'h1357_9BDF; if0.i_wb_sel = 4'hF;
    @(negedge clk);
    chk("b2b_stall", {31'b0, if0.o_wb_stall}, 0);
    if0.i_wb_we = 0;
    @(negedge clk);
    if0.i_wb_stb = 0;
    chk("b2b_wr_ack", {31'b0, if0.o_wb_ack}, 1);
    chk("b2b_wr_data", if0.o_wb_data, 0);
    @(negedge clk);
    chk("b2b_rd_ack", {31'b0, if0.o_wb_ack}, 1);
    chk("b2b_rd_data", if0.o_wb_data, 32'h1357_9BDF);
    @(negedge clk);
    chk("b2b_idle", {31'b0, if0.o_wb_ack}, 0);
    // Ack is suppressed in the very cycle cyc drops, and stb without cyc is ignored
    if0.i_wb_stb = 1; if0.i_wb_addr = 32'h10;
    @(negedge clk);
    if0.i_wb_stb = 0;
    @(negedge clk);
    if0.i_wb_cyc = 0; if0.i_wb_stb = 1;
    #1 chk("gate_ack", {31'b0, if0.o_wb_ack}, 0);
    @(negedge clk);
    chk("gate_after", {31'b0, if0.o_wb_ack | if0.o_wb_err}, 0);
    chk("gate_stall", {31'b0, if0.o_wb_stall}, 0);
    if0.i_wb_cyc = 1; if0.i_wb_stb = 0;
    repeat (3) begin
      @(negedge clk);
      chk("gate_quiet", {31'b0, if0.o_wb_ack | if0.o_wb_err}, 0);
    end
    // Stall-limited streaming on the LAT=3/MAX=2 instance
    stream1(1'b1);
    stream1(1'b0);
    // Abort with two reads in flight on the LAT=3 instance
    @(negedge clk);
    if1.i_wb_cyc = 1; if1.i_wb_stb = 1; if1.i_wb_we = 0; if1.i_wb_addr = 32'h4;
    @(negedge clk);
    if1.i_wb_addr = 32'h8;
    @(negedge clk);
    chk("abort_stall", {31'b0, if1.o_wb_stall}, 1);
    if1.i_wb_cyc = 0;
    @(negedge clk);
    chk("abort_resp", {31'b0, if1.o_wb_ack | if1.o_wb_err}, 0);
    chk("abort_cnt0", {31'b0, if1.o_wb_stall}, 0);
    if1.i_wb_cyc = 1; if1.i_wb_addr = 32'hC;
    @(negedge clk);
    if1.i_wb_stb = 0;
    chk("abort_q1", {31'b0, if1.o_wb_ack | if1.o_wb_err}, 0);
    @(negedge clk);
    chk("abort_q2", {31'b0, if1.o_wb_ack | if1.o_wb_err}, 0);
    @(negedge clk);
    chk("abort_new_ack", {31'b0, if1.o_wb_ack}, 1);
    chk("abort_new_data", if1.o_wb_data, 32'hA500_0003);
    @(negedge clk);
    chk("abort_new_post", {31'b0, if1.o_wb_ack}, 0);
    // Reset while a write is in flight: the write sticks, the ack is dropped
    if0.i_wb_stb = 1; if0.i_wb_we = 1; if0.i_wb_addr = 32'h40;
    if0.i_wb_data = 32'h600D_F00D; if0.i_wb_sel = 4'hF;
    @(negedge clk);
    if0.i_wb_stb = 0; if0.i_wb_we = 0;
    rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    repeat (4) begin
      @(negedge clk);
      chk("rst_mid_quiet", {31'b0, if0.o_wb_ack | if0.o_wb_err | if0.o_wb_stall}, 0);
    end
    run_vec('{1'b0, 32'h40, 32'h0, 4'hF, 1'b0, 32'h600D_F00D});
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
